// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one single-port synchronous Memory (1-cycle read latency, strobe
//   qualified) between port A (CPU, high priority) and port B (debug/DMA).
//   A wins contention unless B has already lost STARVE_LIMIT consecutive
//   cycles. In that case B is forced through for one access.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   reqX/addrX/wdataX/weX          requester X access (X = A, B)
//   grantX                         comb: access issued to memory this cycle
//   doneX                          pulses the cycle after grantX
//   rdataX                         memory dataOut while doneX, else last value
//   mem_addr/dataIn/write/strobe   to Memory
//   mem_dataOut                    from Memory
module memory_arbiter #(
  parameter int addrBusWidth = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqA,
  input  logic [addrBusWidth-1:0] addrA,
  input  logic [7:0]              wdataA,
  input  logic                    weA,
  output logic                    grantA,
  output logic                    doneA,
  output logic [7:0]              rdataA,
  input  logic                    reqB,
  input  logic [addrBusWidth-1:0] addrB,
  input  logic [7:0]              wdataB,
  input  logic                    weB,
  output logic                    grantB,
  output logic                    doneB,
  output logic [7:0]              rdataB,
  output logic [addrBusWidth-1:0] mem_addr,
  output logic [7:0]              mem_dataIn,
  output logic                    mem_write,
  output logic                    mem_strobe,
  input  logic [7:0]              mem_dataOut
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  owner_t     owner, owner_nxt;
  logic [7:0] starveCnt, starveCnt_nxt;
  logic [7:0] rdataA_q, rdataB_q;
  logic       starved;

  assign starved = (starveCnt == LIMIT);

  // Arbitration. Reset masks both grants so no access reaches memory.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (!reset) begin
      if (reqA && reqB) begin
        grantA = !starved;
        grantB = starved;
      end else begin
        grantA = reqA;
        grantB = reqB;
      end
    end
  end

  // Address/data follow B only when B is granted; idle cycles show A's
  // values, which Memory ignores because strobe is low.
  assign mem_addr   = grantB ? addrB  : addrA;
  assign mem_dataIn = grantB ? wdataB : wdataA;
  assign mem_write  = (grantA & weA) | (grantB & weB);
  assign mem_strobe = grantA | grantB;

  always_comb begin
    owner_nxt = OWN_NONE;
    if (grantA)      owner_nxt = OWN_A;
    else if (grantB) owner_nxt = OWN_B;
  end

  // Counts B's consecutive losses; any B grant or B going idle clears it.
  always_comb begin
    starveCnt_nxt = starveCnt;
    if (grantB || !reqB)
      starveCnt_nxt = 8'd0;
    else if (grantA && !starved)
      starveCnt_nxt = starveCnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_NONE;
      starveCnt <= 8'd0;
      rdataA_q  <= 8'd0;
      rdataB_q  <= 8'd0;
    end else begin
      owner     <= owner_nxt;
      starveCnt <= starveCnt_nxt;
      if (doneA) rdataA_q <= mem_dataOut;
      if (doneB) rdataB_q <= mem_dataOut;
    end
  end

  // Masking with reset kills a done that is pending when reset arrives the
  // cycle after the grant. The owner register would otherwise still show it.
  assign doneA  = (owner == OWN_A) && !reset;
  assign doneB  = (owner == OWN_B) && !reset;
  assign rdataA = doneA ? mem_dataOut : rdataA_q;
  assign rdataB = doneB ? mem_dataOut : rdataB_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 256-byte Memory
// (1-cycle latency; a write echoes dataIn on dataOut).
module tb_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqA, weA, reqB, weB;
  logic [7:0] addrA, wdataA, addrB, wdataB;
  logic       grantA, doneA, grantB, doneB;
  logic [7:0] rdataA, rdataB;
  logic [7:0] mem_addr, mem_dataIn, mem_dataOut;
  logic       mem_write, mem_strobe;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [9:0] patB;

  always #5 clk = ~clk;

  memory_arbiter #(.addrBusWidth(8), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .reqA(reqA), .addrA(addrA), .wdataA(wdataA), .weA(weA),
    .grantA(grantA), .doneA(doneA), .rdataA(rdataA),
    .reqB(reqB), .addrB(addrB), .wdataB(wdataB), .weB(weB),
    .grantB(grantB), .doneB(doneB), .rdataB(rdataB),
    .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_write(mem_write),
    .mem_strobe(mem_strobe), .mem_dataOut(mem_dataOut)
  );

  always @(posedge clk) begin
    if (mem_strobe) begin
      if (mem_write) begin
        mem[mem_addr] <= mem_dataIn;
        mem_dataOut   <= mem_dataIn;
      end else begin
        mem_dataOut <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem_dataOut = 8'h00;
    reset = 1'b1;
    reqA = 0; weA = 0; addrA = 8'h10; wdataA = 8'h00;
    reqB = 0; weB = 0; addrB = 8'h20; wdataB = 8'h00;
    cyc(); cyc();

    // Reset state
    chk("rst_grantA", grantA, 0);
    chk("rst_grantB", grantB, 0);
    chk("rst_strobe", mem_strobe, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_doneA", doneA, 0);
    chk("rst_doneB", doneB, 0);

    // Requests during reset are ignored
    reqA = 1; reqB = 1; weA = 1; weB = 1;
    #1;
    chk("rstreq_grantA", grantA, 0);
    chk("rstreq_grantB", grantB, 0);
    chk("rstreq_strobe", mem_strobe, 0);
    chk("rstreq_write", mem_write, 0);
    cyc();
    reset = 0; reqA = 0; reqB = 0; weA = 0; weB = 0;
    #1;
    chk("rstreq_doneA", doneA, 0);
    chk("rstreq_doneB", doneB, 0);
    cyc();

    // A read of 0x10
    reqA = 1; addrA = 8'h10; weA = 0;
    #1;
    chk("t1_grantA", grantA, 1);
    chk("t1_grantB", grantB, 0);
    chk("t1_strobe", mem_strobe, 1);
    chk("t1_addr", mem_addr, 8'h10);
    chk("t1_write", mem_write, 0);
    cyc();
    chk("t1_doneA", doneA, 1);
    chk("t1_rdataA", rdataA, 8'h5A);
    chk("t1_doneB", doneB, 0);
    reqA = 0;
    cyc();
    chk("t1_doneA_off", doneA, 0);
    chk("t1_rdataA_hold", rdataA, 8'h5A);

    // B write 0x20 <- C3, then read it back back-to-back
    reqB = 1; addrB = 8'h20; wdataB = 8'hC3; weB = 1;
    #1;
    chk("t2_grantB_w", grantB, 1);
    chk("t2_write", mem_write, 1);
    chk("t2_addr", mem_addr, 8'h20);
    chk("t2_dataIn", mem_dataIn, 8'hC3);
    cyc();
    chk("t2_doneB_w", doneB, 1);
    chk("t2_rdataB_echo", rdataB, 8'hC3);
    weB = 0;
    #1;
    chk("t2_grantB_r", grantB, 1);
    chk("t2_write_r", mem_write, 0);
    cyc();
    chk("t2_doneB_r", doneB, 1);
    chk("t2_rdataB", rdataB, 8'hC3);
    chk("t2_doneA", doneA, 0);
    reqB = 0;
    cyc();
    chk("t2_doneB_off", doneB, 0);

    // Sustained contention: A,A,A,B,A,A,A,B,A,A
    patB = 10'b0010001000;
    reqA = 1; addrA = 8'h10; reqB = 1; addrB = 8'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_grantA_%0d", i), grantA, !patB[i]);
      chk($sformatf("t3_grantB_%0d", i), grantB, patB[i]);
      cyc();
      chk($sformatf("t3_doneB_%0d", i), doneB, patB[i]);
      if (patB[i]) chk($sformatf("t3_rdataB_%0d", i), rdataB, 8'hC3);
      else         chk($sformatf("t3_rdataA_%0d", i), rdataA, 8'h5A);
    end
    reqA = 0; reqB = 0;
    cyc();

    // Two A wins, B alone, B idle one cycle, then contention restarts at 0
    reqA = 1; reqB = 1;
    #1; chk("t6_pre0_grantA", grantA, 1);
    cyc();
    #1; chk("t6_pre1_grantA", grantA, 1);
    cyc();
    reqA = 0;
    #1; chk("t6_alone_grantB", grantB, 1);
    cyc();
    reqB = 0;
    cyc();
    reqA = 1; reqB = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t6_grantA_%0d", i), grantA, i != 3);
      chk($sformatf("t6_grantB_%0d", i), grantB, i == 3);
      cyc();
    end
    reqA = 0; reqB = 0;
    cyc();

    // Grant on n, reset on n+1: done suppressed, counter cleared
    reqA = 1; reqB = 1;
    #1; chk("t5_pre0_grantA", grantA, 1);
    cyc();
    #1; chk("t5_n_grantA", grantA, 1);
    cyc();
    reset = 1;
    #1;
    chk("t5_doneA_suppressed", doneA, 0);
    chk("t5_rst_strobe", mem_strobe, 0);
    chk("t5_rst_grantB", grantB, 0);
    cyc();
    reset = 0;
    #1;
    chk("t5_post_doneA", doneA, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) #1;
      chk($sformatf("t5_grantA_%0d", i), grantA, i != 3);
      chk($sformatf("t5_grantB_%0d", i), grantB, i == 3);
      cyc();
    end
    reqA = 0; reqB = 0;
    #1;
    chk("t5_idle_strobe", mem_strobe, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
